// File: rtl/alu_funct_decode_stage_if.sv
// ============================================================================
// alu_funct_decode_stage_if: upstream/downstream handshake bundle for the ALU
// funct decode stage. Rev 1.0
// ============================================================================
`default_nettype none

interface alu_funct_decode_stage_if #(
  parameter int TAG_W     = 5,
  parameter int ILL_CNT_W = 8,
  parameter int OP_W      =
`ifdef ALU_MULDIV_EN
    18
`else
    10
`endif
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 ins_r_t;
  logic                 ins_i_t;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [OP_W-1:0]      op;
  logic                 imm_sel;
  logic                 illegal;
  logic [TAG_W-1:0]     out_tag;
  logic [ILL_CNT_W-1:0] ill_count;

  // The stage itself
  modport slave (
    input  in_valid, ins_r_t, ins_i_t, funct3, funct7, in_tag, out_ready,
    output in_ready, out_valid, op, imm_sel, illegal, out_tag, ill_count
  );

  // The surrounding pipeline (decoder upstream, issue downstream)
  modport master (
    output in_valid, ins_r_t, ins_i_t, funct3, funct7, in_tag, out_ready,
    input  in_ready, out_valid, op, imm_sel, illegal, out_tag, ill_count
  );
endinterface

`default_nettype wire

// File: rtl/alu_funct_decode_stage.sv
// ============================================================================
// alu_funct_decode_stage: funct3/funct7 -> one-hot ALU op decoder feeding a
// 2-entry skid queue. Optional M-extension decode: ALU_MULDIV_EN. Rev 1.0
// ============================================================================
`default_nettype none

module alu_funct_decode_stage #(
  parameter int TAG_W     = 5,
  parameter int ILL_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  alu_funct_decode_stage_if.slave    bus
);

`ifdef ALU_MULDIV_EN
  localparam int OP_W = 18;
`else
  localparam int OP_W = 10;
`endif

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
`ifdef ALU_MULDIV_EN
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic                 in_ready_q, in_ready_nxt;
  logic                 head, tail;
  logic [ILL_CNT_W-1:0] ill_cnt;

  logic [OP_W-1:0]      q_op  [2];
  logic                 q_imm [2];
  logic                 q_ill [2];
  logic [TAG_W-1:0]     q_tag [2];

  logic [9:0]           base_onehot;
  logic [OP_W-1:0]      dec_op;
  logic                 dec_ill;
  logic                 dec_imm;
  logic                 push, pop, out_valid;

  assign out_valid = (state != S_EMPTY);
  assign push      = bus.in_valid && in_ready_q;
  assign pop       = out_valid && bus.out_ready;

  // funct3 ordering for the funct7=0 group: ADD SLL SLT SLTU XOR SRL OR AND
  always_comb begin
    base_onehot = 10'b0;
    case (bus.funct3)
      3'b000:  base_onehot[0] = 1'b1;
      3'b001:  base_onehot[2] = 1'b1;
      3'b010:  base_onehot[3] = 1'b1;
      3'b011:  base_onehot[4] = 1'b1;
      3'b100:  base_onehot[5] = 1'b1;
      3'b101:  base_onehot[6] = 1'b1;
      3'b110:  base_onehot[8] = 1'b1;
      default: base_onehot[9] = 1'b1;
    endcase
  end

  always_comb begin
    dec_op  = '0;
    dec_ill = 1'b0;
    dec_imm = 1'b0;
    if (bus.ins_r_t && bus.ins_i_t) begin
      dec_ill = 1'b1;
    end else if (bus.ins_r_t) begin
      if (bus.funct7 == F7_BASE) begin
        dec_op[9:0] = base_onehot;
      end else if (bus.funct7 == F7_ALT && bus.funct3 == 3'b000) begin
        dec_op[1] = 1'b1;
      end else if (bus.funct7 == F7_ALT && bus.funct3 == 3'b101) begin
        dec_op[7] = 1'b1;
`ifdef ALU_MULDIV_EN
      end else if (bus.funct7 == F7_MULDIV) begin
        dec_op[OP_W-1:10] = 8'(8'b1 << bus.funct3);
`endif
      end else begin
        dec_ill = 1'b1;
      end
    end else if (bus.ins_i_t) begin
      // Immediate shifts reuse funct7 as the shift-type field; others ignore it
      if (bus.funct3 == 3'b001) begin
        if (bus.funct7 == F7_BASE) dec_op[2] = 1'b1;
        else                       dec_ill   = 1'b1;
      end else if (bus.funct3 == 3'b101) begin
        if (bus.funct7 == F7_BASE)     dec_op[6] = 1'b1;
        else if (bus.funct7 == F7_ALT) dec_op[7] = 1'b1;
        else                           dec_ill   = 1'b1;
      end else begin
        dec_op[9:0] = base_onehot;
      end
      dec_imm = !dec_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
      head       <= 1'b0;
      tail       <= 1'b0;
      ill_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= in_ready_nxt;
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      if (push && dec_ill && (ill_cnt != '1)) ill_cnt <= ill_cnt + 1'b1;
    end
  end

  // in_ready is registered from the next state so out_ready never reaches it
  always_comb begin
    state_nxt    = state;
    in_ready_nxt = 1'b1;
    case (state)
      S_EMPTY: if (push) state_nxt = S_ONE;
      S_ONE: begin
        if (push && !pop)      state_nxt = S_FULL;
        else if (pop && !push) state_nxt = S_EMPTY;
      end
      S_FULL:  if (pop) state_nxt = S_ONE;
      default: state_nxt = S_EMPTY;
    endcase
    if (state_nxt == S_FULL) in_ready_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        q_op[k]  <= '0;
        q_imm[k] <= 1'b0;
        q_ill[k] <= 1'b0;
        q_tag[k] <= '0;
      end
    end else if (push) begin
      q_op[tail]  <= dec_op;
      q_imm[tail] <= dec_imm;
      q_ill[tail] <= dec_ill;
      q_tag[tail] <= bus.in_tag;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.op        = out_valid ? q_op[head]  : '0;
  assign bus.imm_sel   = out_valid ? q_imm[head] : 1'b0;
  assign bus.illegal   = out_valid ? q_ill[head] : 1'b0;
  assign bus.out_tag   = out_valid ? q_tag[head] : '0;
  assign bus.ill_count = ill_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_funct_decode_stage.sv
// ============================================================================
// tb_alu_funct_decode_stage: directed self-checking bench for the ALU funct
// decode stage. Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_funct_decode_stage;

`ifdef ALU_MULDIV_EN
  localparam int OP_W = 18;
`else
  localparam int OP_W = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_ill = 0;

  always #5 clk = ~clk;

  alu_funct_decode_stage_if #(.TAG_W(5), .ILL_CNT_W(8), .OP_W(OP_W)) bus ();

  alu_funct_decode_stage #(.TAG_W(5), .ILL_CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic i, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] tag);
    bus.ins_r_t = r;
    bus.ins_i_t = i;
    bus.funct3  = f3;
    bus.funct7  = f7;
    bus.in_tag  = tag;
  endtask

  // Single accept into an empty queue, leaves in_valid low afterwards
  task automatic send(input logic r, input logic i, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] tag);
    drive(r, i, f3, f7, tag);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] op,
                             input logic imm, input logic ill, input logic [4:0] t);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".op"},    32'(bus.op),        op);
    check({tag, ".imm"},   32'(bus.imm_sel),   32'(imm));
    check({tag, ".ill"},   32'(bus.illegal),   32'(ill));
    check({tag, ".tag"},   32'(bus.out_tag),   32'(t));
    check({tag, ".cnt"},   32'(bus.ill_count), 32'(exp_ill));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 7'd0, 5'd0);
    step();
    step();
    rst = 1'b0;

    check("rst.valid", 32'(bus.out_valid), 32'd0);
    check("rst.ready", 32'(bus.in_ready),  32'd1);
    check("rst.op",    32'(bus.op),        32'd0);
    check("rst.ill",   32'(bus.illegal),   32'd0);
    check("rst.imm",   32'(bus.imm_sel),   32'd0);
    check("rst.tag",   32'(bus.out_tag),   32'd0);
    check("rst.cnt",   32'(bus.ill_count), 32'd0);

    bus.out_ready = 1'b1;
    send(1'b1, 1'b0, 3'b000, 7'b0000000, 5'd3);
    expect_head("add", 32'h001, 1'b0, 1'b0, 5'd3);
    step();
    check("drain.valid", 32'(bus.out_valid), 32'd0);

    send(1'b1, 1'b0, 3'b101, 7'b0100000, 5'd4);
    expect_head("sra", 32'h080, 1'b0, 1'b0, 5'd4);
    step();
    send(1'b0, 1'b1, 3'b101, 7'b0100000, 5'd5);
    expect_head("srai", 32'h080, 1'b1, 1'b0, 5'd5);
    step();
    send(1'b0, 1'b1, 3'b000, 7'b1111111, 5'd6);
    expect_head("addi_f7", 32'h001, 1'b1, 1'b0, 5'd6);
    step();
    send(1'b1, 1'b0, 3'b111, 7'b0000000, 5'd9);
    expect_head("and", 32'h200, 1'b0, 1'b0, 5'd9);
    step();
    send(1'b0, 1'b0, 3'b000, 7'b0000000, 5'd10);
    expect_head("nonalu", 32'h000, 1'b0, 1'b0, 5'd10);
    step();

    send(1'b1, 1'b0, 3'b010, 7'b0100000, 5'd11);
    exp_ill = 1;
    expect_head("ill_slt", 32'h000, 1'b0, 1'b1, 5'd11);
    step();
    send(1'b1, 1'b1, 3'b000, 7'b0000000, 5'd12);
    exp_ill = 2;
    expect_head("ill_both", 32'h000, 1'b0, 1'b1, 5'd12);
    step();
    send(1'b0, 1'b1, 3'b001, 7'b0100000, 5'd13);
    exp_ill = 3;
    expect_head("ill_slli", 32'h000, 1'b0, 1'b1, 5'd13);
    step();
    send(1'b0, 1'b1, 3'b101, 7'b0000001, 5'd14);
    exp_ill = 4;
    expect_head("ill_srxi", 32'h000, 1'b0, 1'b1, 5'd14);
    step();

    send(1'b1, 1'b0, 3'b100, 7'b0000001, 5'd15);
`ifdef ALU_MULDIV_EN
    expect_head("div", 32'h04000, 1'b0, 1'b0, 5'd15);
`else
    exp_ill = 5;
    expect_head("div_ill", 32'h000, 1'b0, 1'b1, 5'd15);
`endif
    step();

    // Back-pressure: two entries fill the queue, third must wait upstream
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 3'b000, 7'b0000000, 5'd1);
    bus.in_valid = 1'b1;
    step();
    check("bp1.ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 1'b0, 3'b000, 7'b0000000, 5'd2);
    step();
    check("bp2.ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 1'b0, 3'b000, 7'b0000000, 5'd3);
    step();
    check("bp3.ready", 32'(bus.in_ready), 32'd0);
    expect_head("bp_hold", 32'h001, 1'b0, 1'b0, 5'd1);
    bus.out_ready = 1'b1;
    step();
    expect_head("bp_t2", 32'h001, 1'b0, 1'b0, 5'd2);
    check("bp4.ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    expect_head("bp_t3", 32'h001, 1'b0, 1'b0, 5'd3);
    step();
    check("bp.empty", 32'(bus.out_valid), 32'd0);

    // Saturation of the illegal counter under continuous streaming
    drive(1'b1, 1'b0, 3'b000, 7'b1111111, 5'd20);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 260; k++) begin
      step();
      if (exp_ill < 255) exp_ill++;
    end
    bus.in_valid = 1'b0;
    expect_head("sat", 32'h000, 1'b0, 1'b1, 5'd20);
    step();

    // Reset with two entries held
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 3'b110, 7'b0000000, 5'd7);
    bus.in_valid = 1'b1;
    step();
    drive(1'b1, 1'b0, 3'b110, 7'b0000000, 5'd8);
    step();
    bus.in_valid = 1'b0;
    expect_head("pre_rst", 32'h100, 1'b0, 1'b0, 5'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_ill = 0;
    check("mrst.valid", 32'(bus.out_valid), 32'd0);
    check("mrst.ready", 32'(bus.in_ready),  32'd1);
    check("mrst.cnt",   32'(bus.ill_count), 32'd0);
    check("mrst.op",    32'(bus.op),        32'd0);
    check("mrst.tag",   32'(bus.out_tag),   32'd0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("mrst.stale", 32'(bus.out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_funct_decode_stage.md
# alu_funct_decode_stage

Registered, handshaked ALU operation decoder for the execute-side control path. Accepts R-type and I-type ALU instructions (type strobes, funct3, funct7), decodes them into a one-hot ALU operation vector, flags illegal encodings and buffers results in a 2-entry skid queue. It sits between the main instruction decoder and the ALU operand/issue stage, so back-pressure from issue never forces decode to recompute.

## Interface
- `TAG_W`, 5: width of the opaque tag (destination register index) carried alongside each decode.
- `ILL_CNT_W`, 8: width of the saturating illegal-encoding counter.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage can accept; high when fewer than 2 entries held.
- `ins_r_t`  in  1  instruction is R-type ALU (OP).
- `ins_i_t`  in  1  instruction is I-type ALU (OP-IMM).
- `funct3`  in  3  instruction bits [14:12].
- `funct7`  in  7  instruction bits [31:25].
- `in_tag`  in  TAG_W  passthrough tag.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream consumes head when high with `out_valid`.
- `op`  out  OP_W  one-hot ALU op, bit order ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND (bits 0..9); OP_W = 10, or 18 with MULDIV_EN.
- `imm_sel`  out  1  operand B is immediate (entry was I-type).
- `illegal`  out  1  entry is an illegal encoding; `op` all-zero.
- `out_tag`  out  TAG_W  tag of head entry.
- `ill_count`  out  ILL_CNT_W  number of illegal entries accepted since reset, saturating.

## Operation
- Accept when `in_valid && in_ready`; decode is combinational on inputs, result written into queue.
- R-type: funct7 = 0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3 (000..111, order as bit list minus SUB/SRA). funct7 = 0100000 legal only with funct3 000 (SUB) or 101 (SRA); any other funct7 → illegal.
- I-type: funct3 000,010,011,100,110,111 decode ignoring funct7 (ADDI..ANDI); funct3 001 needs funct7 = 0000000 (SLLI); funct3 101: 0000000 → SRL, 0100000 → SRA, else illegal. `imm_sel`=1.
- Both `ins_r_t` and `ins_i_t` high → illegal. Neither high → non-ALU entry: `op`=0, `illegal`=0, `imm_sel`=0 (still queued, preserves order).
- Illegal entries: `op`=0, `imm_sel`=0, `illegal`=1; `ill_count` increments by 1 on acceptance, holds at all-ones.
- Queue states: EMPTY (count 0) → ONE on push; ONE → FULL on push without pop, → EMPTY on pop without push, stays ONE on push+pop; FULL → ONE on pop. No push in FULL (`in_ready`=0).
- Ordering strictly FIFO; head pointer wraps 1→0.

## Timing
- Latency 1: instruction accepted at edge N is visible on `out_*` after edge N (cycle N+1) if queue was empty.
- Throughput 1/cycle with `out_ready` held high; `in_ready` is a registered function of count (no combinational path from `out_ready`).
- Simultaneous push and pop in ONE: head leaves, new entry becomes head next cycle, count stays 1.
- `out_*` held stable while `out_valid && !out_ready`.
- Reset: count 0, state EMPTY, `out_valid`=0, `in_ready`=1 in the cycle after reset, `op`=0, `illegal`=0, `imm_sel`=0, `out_tag`=0, `ill_count`=0. Reset mid-operation discards queued entries; count is not carried over.

## Configuration
- `ALU_MULDIV_EN`: defined → OP_W = 18, bits 10..17 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, selected for R-type with funct7 = 0000001 by funct3 000..111. Undefined → OP_W = 10, R-type funct7 = 0000001 is illegal. I-type never decodes M ops.

## Test plan
- Reset, then R-type funct3=000 funct7=0000000 tag=3 with `out_ready`=1 → next cycle `out_valid`=1, `op`=0x001, `out_tag`=3, `illegal`=0.
- R-type funct3=101 funct7=0100000, then I-type funct3=101 funct7=0100000 → `op`=0x080 both, `imm_sel` 0 then 1.
- R-type funct3=010 funct7=0100000 → `illegal`=1, `op`=0, `ill_count` 0→1; 260 illegal pushes with ILL_CNT_W=8 → `ill_count`=255.
- `out_ready`=0, push 3 back-to-back → `in_ready` falls after second accept, third held upstream; raise `out_ready` → outputs in order, tags 1,2,3.
- R-type funct7=0000001 funct3=100 → with `ALU_MULDIV_EN` `op` bit 14 (DIV) set; without it `illegal`=1.
- Two entries queued, assert `rst` for one cycle → `out_valid`=0, `in_ready`=1, `ill_count`=0, no stale entry emitted afterwards.
